// File: rtl/fixed_int_pkg.sv
// Shared helpers for fixed-point to integer conversion.
// Width, rounding-constant and output-range functions.
package fixed_int_pkg;

  function automatic int inter_width(int in_width, int in_exp);
    return in_width + ((in_exp > 0) ? in_exp : 0) + 1;
  endfunction

  function automatic longint rnd_const(int in_exp);
    if (in_exp < 0) return longint'(1) << (-in_exp - 1);
    return 0;
  endfunction

  function automatic longint out_max(int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint out_min(int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam int     DEF_OUT_WIDTH = 8;
  localparam longint DEF_OUT_MAX   = out_max(DEF_OUT_WIDTH);
  localparam longint DEF_OUT_MIN   = out_min(DEF_OUT_WIDTH);

endpackage

// File: rtl/fixed_to_int_stream_sat_clip.sv
// Combinational clip of a wide signed value to OUT_W bits.
// sat is high whenever the value had to be clamped.
module sat_clip
  import fixed_int_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_W =
    IN_W'(out_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_W =
    IN_W'(out_min(OUT_W));
  localparam logic signed [OUT_W-1:0] MAX_O =
    OUT_W'(out_max(OUT_W));
  localparam logic signed [OUT_W-1:0] MIN_O =
    OUT_W'(out_min(OUT_W));

  // clamp to the representable output range
  always_comb begin
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if (din > MAX_W) begin
      dout = MAX_O;
      sat  = 1'b1;
    end else if (din < MIN_W) begin
      dout = MIN_O;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/fixed_to_int_stream.sv
// Two-stage streaming fixed-point to saturated integer converter.
// S1 rounds/shifts, S2 clips; saturation stats count on S2 load.
module fixed_to_int_stream
  import fixed_int_pkg::*;
#(
  parameter int IN_WIDTH  = 25,
  parameter int IN_EXP    = -16,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sat,
  output logic                        sat_flag,
  output logic [CNT_WIDTH-1:0]        sat_count
);

  localparam int IW = inter_width(IN_WIDTH, IN_EXP);

  logic signed [IW-1:0]        in_ext;
  logic signed [IW-1:0]        rounded;
  logic signed [OUT_WIDTH-1:0] clip_data;
  logic                        clip_sat;

  logic                        s1_valid_q, s1_valid_d;
  logic signed [IW-1:0]        s1_data_q, s1_data_d;
  logic                        s2_valid_q, s2_valid_d;
  logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                        s2_sat_q, s2_sat_d;
  logic                        sat_flag_q, sat_flag_d;
  logic [CNT_WIDTH-1:0]        sat_cnt_q, sat_cnt_d;

  logic s2_load, s1_load, in_fire, sat_evt;

  assign in_ext = IW'(in_data);

  if (IN_EXP < 0) begin : g_round
    localparam int RSH = -IN_EXP;
    localparam logic signed [IW-1:0] RND =
      IW'(rnd_const(IN_EXP));
    logic signed [IW-1:0] sum;
    assign sum     = in_ext + RND;
    assign rounded = sum >>> RSH;
  end else begin : g_shift
    assign rounded = in_ext <<< IN_EXP;
  end

  sat_clip #(
    .IN_W  (IW),
    .OUT_W (OUT_WIDTH)
  ) u_clip (
    .din  (s1_data_q),
    .dout (clip_data),
    .sat  (clip_sat)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load && !rst;
  assign in_fire  = in_valid && in_ready;
  assign sat_evt  = s2_load && s1_valid_q && clip_sat;

  // pipeline advance and saturation statistics
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (s1_load) s1_valid_d = in_fire;
    if (in_fire) s1_data_d = rounded;
    if (s2_load) s2_valid_d = s1_valid_q;
    if (s2_load && s1_valid_q) begin
      s2_data_d = clip_data;
      s2_sat_d  = clip_sat;
    end
    if (clear) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end else if (sat_evt) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != '1) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sat   = s2_sat_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_cnt_q;

endmodule
